// File: rtl/memory_access_stage.sv
// Memory stage: EX/MEM register, 2^ADDR_W x 20 synchronous data RAM, BEQ resolution, MEM/WB register.
module memory_access_stage #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic        inValid,
    input  logic [19:0] instructionIn,
    input  logic [19:0] aluResult,
    input  logic [19:0] storeData,
    input  logic        ulaZero,
    output logic        branchTaken,
    output logic [19:0] branchTarget,
    output logic        wbValid,
    output logic        wbWriteEnable,
    output logic [3:0]  wbRegAddr,
    output logic [19:0] wbData,
    output logic [19:0] instructionOut
);

    localparam int unsigned DATA_W = 20;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    localparam logic [3:0] OP_ALU = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_BEQ = 4'h3;

    // EX/MEM register fields
    logic              exmem_valid_q;
    logic [DATA_W-1:0] exmem_instr_q;
    logic [DATA_W-1:0] exmem_alu_q;
    logic [DATA_W-1:0] exmem_store_q;
    logic              exmem_zero_q;

    // MEM/WB register fields
    logic              memwb_valid_q;
    logic [DATA_W-1:0] memwb_instr_q;
    logic [3:0]        memwb_rd_q;
    logic [DATA_W-1:0] memwb_alu_q;
    logic              memwb_is_load_q;

    // RAM storage and read port
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic [3:0]        exmem_op_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              mem_we_c;
    logic [3:0]        memwb_op_c;

    assign exmem_op_c = exmem_instr_q[19:16];
    assign mem_addr_c = exmem_alu_q[ADDR_W-1:0];
    assign mem_we_c   = resetn && !stall && exmem_valid_q && (exmem_op_c == OP_ST);
    assign memwb_op_c = memwb_instr_q[19:16];

    // EX/MEM capture: flush kills the incoming slot even while stalled
    always_ff @(posedge clock) begin
        if (!resetn) begin
            exmem_valid_q <= 1'b0;
            exmem_instr_q <= '0;
            exmem_alu_q   <= '0;
            exmem_store_q <= '0;
            exmem_zero_q  <= 1'b0;
        end else if (flush) begin
            exmem_valid_q <= 1'b0;
        end else if (!stall) begin
            exmem_valid_q <= inValid;
            exmem_instr_q <= instructionIn;
            exmem_alu_q   <= aluResult;
            exmem_store_q <= storeData;
            exmem_zero_q  <= ulaZero;
        end
    end

    // Data RAM: write on unstalled ST, read port re-clocked only when not stalled
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem_q[mem_addr_c] <= exmem_store_q;
        end
        if (!stall) begin
            rd_data_q <= mem_q[mem_addr_c];
        end
    end

    // MEM/WB capture on every unstalled edge
    always_ff @(posedge clock) begin
        if (!resetn) begin
            memwb_valid_q   <= 1'b0;
            memwb_instr_q   <= '0;
            memwb_rd_q      <= '0;
            memwb_alu_q     <= '0;
            memwb_is_load_q <= 1'b0;
        end else if (!stall) begin
            memwb_valid_q   <= exmem_valid_q;
            memwb_instr_q   <= exmem_instr_q;
            memwb_rd_q      <= exmem_instr_q[15:12];
            memwb_alu_q     <= exmem_alu_q;
            memwb_is_load_q <= exmem_valid_q && (exmem_op_c == OP_LD);
        end
    end

    // Branch resolution straight from EX/MEM; write-back bundle from MEM/WB
    always_comb begin
        branchTaken    = exmem_valid_q && (exmem_op_c == OP_BEQ) && exmem_zero_q;
        branchTarget   = {12'b0, exmem_instr_q[7:0]};
        wbValid        = memwb_valid_q;
        wbWriteEnable  = memwb_valid_q && ((memwb_op_c == OP_ALU) || (memwb_op_c == OP_LD));
        wbRegAddr      = memwb_rd_q;
        wbData         = memwb_is_load_q ? rd_data_q : memwb_alu_q;
        instructionOut = memwb_instr_q;
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: stimulus pushes expected write-back records, monitor pops them.
module tb_memory_access_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic        stall;
    logic        flush;
    logic        inValid;
    logic [19:0] instructionIn;
    logic [19:0] aluResult;
    logic [19:0] storeData;
    logic        ulaZero;
    logic        branchTaken;
    logic [19:0] branchTarget;
    logic        wbValid;
    logic        wbWriteEnable;
    logic [3:0]  wbRegAddr;
    logic [19:0] wbData;
    logic [19:0] instructionOut;

    memory_access_stage #(.ADDR_W(8)) dut (
        .clock(clock),
        .resetn(resetn),
        .stall(stall),
        .flush(flush),
        .inValid(inValid),
        .instructionIn(instructionIn),
        .aluResult(aluResult),
        .storeData(storeData),
        .ulaZero(ulaZero),
        .branchTaken(branchTaken),
        .branchTarget(branchTarget),
        .wbValid(wbValid),
        .wbWriteEnable(wbWriteEnable),
        .wbRegAddr(wbRegAddr),
        .wbData(wbData),
        .instructionOut(instructionOut)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [19:0] instr;
        logic        we;
        logic [3:0]  rd;
        logic [19:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic captured = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] rd, input logic [11:0] low);
        return {op, rd, low};
    endfunction

    task automatic push(input logic [19:0] instr, input logic we, input logic [3:0] rd, input logic [19:0] data);
        exp_t e;
        e.instr = instr;
        e.we    = we;
        e.rd    = rd;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [19:0] instr, input logic [19:0] alu,
                         input logic [19:0] sd, input logic z);
        inValid       = v;
        instructionIn = instr;
        aluResult     = alu;
        storeData     = sd;
        ulaZero       = z;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Remember whether MEM/WB was allowed to update on the last edge
    always @(posedge clock) captured = resetn && !stall;

    // Monitor: every freshly captured valid MEM/WB entry is matched against the queue
    always @(negedge clock) begin
        if (captured && wbValid) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'(instructionOut), 32'h0);
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got instr 0x%0h with empty queue", instructionOut);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_instr", 32'(instructionOut), 32'(e.instr));
                check("wb_we",    32'(wbWriteEnable),  32'(e.we));
                check("wb_rd",    32'(wbRegAddr),      32'(e.rd));
                check("wb_data",  32'(wbData),         32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with stall, flush and junk asserted
        resetn = 1'b0;
        stall  = 1'b1;
        flush  = 1'b1;
        drive(1'b1, mk(4'h2, 4'h0, 12'h005), 20'h00005, 20'h5A5A5, 1'b1);
        step();
        step();
        @(negedge clock);
        check("rst_branchTaken",  32'(branchTaken),    32'h0);
        check("rst_branchTarget", 32'(branchTarget),   32'h0);
        check("rst_wbValid",      32'(wbValid),        32'h0);
        check("rst_wbWE",         32'(wbWriteEnable),  32'h0);
        check("rst_wbRegAddr",    32'(wbRegAddr),      32'h0);
        check("rst_wbData",       32'(wbData),         32'h0);
        check("rst_instrOut",     32'(instructionOut), 32'h0);
        resetn = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0);
        step();
        step();
        @(negedge clock);
        check("idle_wbValid",     32'(wbValid),     32'h0);
        check("idle_branchTaken", 32'(branchTaken), 32'h0);

        // Store then load of the same word (0x105 wraps to 0x05), then back-to-back ALU ops
        drive(1'b1, mk(4'h2, 4'h0, 12'h005), 20'h00005, 20'hABCDE, 1'b0);
        push(mk(4'h2, 4'h0, 12'h005), 1'b0, 4'h0, 20'h00005);
        step();
        drive(1'b1, mk(4'h1, 4'h3, 12'h105), 20'h00105, 20'h0, 1'b0);
        push(mk(4'h1, 4'h3, 12'h105), 1'b1, 4'h3, 20'hABCDE);
        step();
        drive(1'b1, mk(4'h0, 4'h1, 12'h000), 20'h00011, 20'h0, 1'b0);
        push(mk(4'h0, 4'h1, 12'h000), 1'b1, 4'h1, 20'h00011);
        step();
        drive(1'b1, mk(4'h0, 4'h2, 12'h000), 20'hFFFFF, 20'h0, 1'b0);
        push(mk(4'h0, 4'h2, 12'h000), 1'b1, 4'h2, 20'hFFFFF);
        step();
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0);
        step();
        step();
        step();

        // BEQ taken then not taken
        drive(1'b1, 20'h3002A, 20'h0, 20'h0, 1'b1);
        push(20'h3002A, 1'b0, 4'h0, 20'h0);
        step();
        @(negedge clock);
        check("beq_taken",        32'(branchTaken),  32'h1);
        check("beq_target",       32'(branchTarget), 32'h0002A);
        drive(1'b1, 20'h3002A, 20'h0, 20'h0, 1'b0);
        push(20'h3002A, 1'b0, 4'h0, 20'h0);
        step();
        @(negedge clock);
        check("beq_not_taken",    32'(branchTaken),   32'h0);
        check("beq_target2",      32'(branchTarget),  32'h0002A);
        check("beq_wbValid",      32'(wbValid),       32'h1);
        check("beq_no_we",        32'(wbWriteEnable), 32'h0);
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0);
        step();
        @(negedge clock);
        check("beq_drop",         32'(branchTaken),   32'h0);
        step();

        // Store held in EX/MEM by a 3-cycle stall while a different storeData is driven
        drive(1'b1, mk(4'h0, 4'h5, 12'h000), 20'h0ABCD, 20'h0, 1'b0);
        push(mk(4'h0, 4'h5, 12'h000), 1'b1, 4'h5, 20'h0ABCD);
        step();
        drive(1'b1, mk(4'h2, 4'h0, 12'h010), 20'h00010, 20'h12345, 1'b0);
        push(mk(4'h2, 4'h0, 12'h010), 1'b0, 4'h0, 20'h00010);
        step();
        stall = 1'b1;
        drive(1'b1, mk(4'h1, 4'h9, 12'h010), 20'h00010, 20'h54321, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clock);
            check("stall_wbValid", 32'(wbValid),        32'h1);
            check("stall_wbRd",    32'(wbRegAddr),      32'h5);
            check("stall_wbData",  32'(wbData),         32'h0ABCD);
            check("stall_wbWE",    32'(wbWriteEnable),  32'h1);
            check("stall_instr",   32'(instructionOut), 32'(mk(4'h0, 4'h5, 12'h000)));
        end
        stall = 1'b0;
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0);
        step();
        drive(1'b1, mk(4'h1, 4'h4, 12'h010), 20'h00010, 20'h99999, 1'b0);
        push(mk(4'h1, 4'h4, 12'h010), 1'b1, 4'h4, 20'h12345);
        step();
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0);
        step();
        step();

        // Flush kills an incoming LD
        flush = 1'b1;
        drive(1'b1, mk(4'h1, 4'h7, 12'h005), 20'h00005, 20'h0, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0);
        step();
        @(negedge clock);
        check("flush_wbValid", 32'(wbValid),       32'h0);
        check("flush_wbWE",    32'(wbWriteEnable), 32'h0);

        // Flush together with stall: EX/MEM bubbles, MEM/WB holds
        drive(1'b1, mk(4'h0, 4'h6, 12'h000), 20'h00666, 20'h0, 1'b0);
        push(mk(4'h0, 4'h6, 12'h000), 1'b1, 4'h6, 20'h00666);
        step();
        drive(1'b1, mk(4'h0, 4'h8, 12'h000), 20'h00888, 20'h0, 1'b0);
        step();
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0);
        step();
        @(negedge clock);
        check("fs_wbValid", 32'(wbValid),   32'h1);
        check("fs_wbRd",    32'(wbRegAddr), 32'h6);
        check("fs_wbData",  32'(wbData),    32'h00666);
        stall = 1'b0;
        flush = 1'b0;
        step();
        @(negedge clock);
        check("fs_killed",  32'(wbValid),   32'h0);
        step();
        step();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory stage of the 20-bit five-stage pipeline, directly downstream of the execute stage. It latches the execute outputs into an EX/MEM register, performs data-memory loads and stores against an internal 256×20 synchronous RAM, resolves BEQ, and presents a registered MEM/WB bundle to the write-back stage. Stall and flush inputs come from the hazard unit.

## Interface
Parameters:
- ADDR_W, 8, data-memory address width; depth = 2^ADDR_W words of 20 bits

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- stall  in  1  hold both pipeline registers and suppress memory writes
- flush  in  1  kill the instruction entering EX/MEM
- inValid  in  1  execute stage presents a real instruction
- instructionIn  in  20  instruction propagated from execute
- aluResult  in  20  execute ALU result (address for LD/ST, data for ALU ops)
- storeData  in  20  register read data 2 from execute (ST data)
- ulaZero  in  1  execute operand-equality flag
- branchTaken  out  1  BEQ in EX/MEM with latched zero = 1 (combinational from EX/MEM)
- branchTarget  out  20  {12'b0, EX/MEM instruction[7:0]}
- wbValid  out  1  MEM/WB holds a real instruction
- wbWriteEnable  out  1  write-back must write the register file
- wbRegAddr  out  4  destination register
- wbData  out  20  load data or ALU result
- instructionOut  out  20  instruction in MEM/WB

## Operation
- Encoding: opcode = instruction[19:16]; rd = instruction[15:12]. 4'h0 ALU op (writes rd with aluResult); 4'h1 LD (writes rd with mem[aluResult[ADDR_W-1:0]]); 4'h2 ST (mem[aluResult[ADDR_W-1:0]] <= storeData, no register write); 4'h3 BEQ (no memory, no write); any other opcode = NOP (valid, no side effects).
- EX/MEM register: {valid, instruction, aluResult, storeData, zero}. On an edge with resetn=1: flush=1 -> valid <= 0 (other fields don't care), regardless of stall; else stall=1 -> hold; else capture inputs with valid <= inValid.
- Memory: store write occurs on the edge when EX/MEM valid=1, opcode=ST, stall=0. Read is synchronous: address from EX/MEM aluResult sampled every non-stalled edge. Only one instruction occupies EX/MEM, so no same-edge read/write conflict exists; a LD in the slot after a ST to the same address returns the new data.
- MEM/WB register: on a non-stalled edge captures {valid, instruction, rd, aluResult, isLoad}. wbData = isLoad ? RAM read data : latched aluResult. wbWriteEnable = wbValid && opcode ∈ {ALU, LD}.
- branchTaken = EX/MEM valid && opcode=BEQ && zero. Asserted for exactly as long as the BEQ sits in EX/MEM (one cycle unless stalled). Hazard unit responds with flush.
- Addresses use only aluResult[ADDR_W-1:0]; upper bits ignored (wrap modulo depth).

## Timing
- Reset (resetn=0 on an edge): EX/MEM and MEM/WB cleared to all-zero; thereafter branchTaken=0, branchTarget=0, wbValid=0, wbWriteEnable=0, wbRegAddr=0, wbData=0, instructionOut=0. RAM contents are not reset and not written during reset. Reset overrides stall and flush; reset mid-store cancels the write.
- Latency: instruction sampled at edge N appears on wb* outputs after edge N+1 (2-edge latency, throughput one per cycle).
- Stall held K cycles: all outputs frozen, no RAM write; store executes exactly once after stall releases.
- stall and flush together: EX/MEM becomes bubble; MEM/WB holds.
- wbData for a held LD stays stable during stall (RAM read port not re-clocked).

## Test plan
- Reset: drive resetn=0 with stall=1, flush=1, junk inputs for 2 edges -> all outputs 0; release -> remain 0 until inValid.
- Store then load: ST addr 0x005 data 0xABCDE, next cycle LD rd=3 addr 0x105 -> LD write-back shows wbRegAddr=3, wbData=0xABCDE, wbWriteEnable=1 two edges after LD sampled.
- ALU pass-through: back-to-back ALU ops rd=1 result 0x00011, rd=2 result 0xFFFFF -> consecutive wb cycles with matching values, no bubbles.
- BEQ: instruction 0x3_0_0_2A with ulaZero=1 -> branchTaken=1, branchTarget=0x0002A for one cycle; with ulaZero=0 -> branchTaken=0; BEQ never asserts wbWriteEnable.
- Stall: ST addr 0x010 data 0x12345 stalled 3 cycles in EX/MEM, with a different value driven on storeData -> outputs frozen, single write of 0x12345; later LD 0x010 returns 0x12345.
- Flush: flush with inValid=1 LD rd=7 -> no write-back for that slot (wbValid=0); flush+stall -> MEM/WB contents unchanged.
